// File: rtl/fp16_pkg.sv
// Shared types and constants for the binary16 operand-alignment datapath.
package fp16_pkg;

    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int GRS_W     = 3;
    localparam int MAX_SHIFT = FRAC_W + 1 + GRS_W;
    localparam int MAN_W     = FRAC_W + 1;
    localparam int SMAN_W    = MAN_W + GRS_W;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_fields_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational binary16 field split: effective exponent, significand and
// zero / inf-nan classification.
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [15:0]      word,
    output logic             sign,
    output logic [EXP_W-1:0] eff_exp,
    output logic [MAN_W-1:0] man,
    output logic             is_zero,
    output logic             is_special
);

    fp16_fields_t f;
    logic         hidden;

    always_comb begin
        f          = word;
        hidden     = (f.exp != '0);
        sign       = f.sign;
        // Subnormals share the exponent of the smallest normal.
        eff_exp    = hidden ? f.exp : EXP_W'(1);
        man        = {hidden, f.frac};
        is_zero    = (f.exp == '0) && (f.frac == '0);
        is_special = (f.exp == EXP_MAX);
    end

endmodule

// File: rtl/fp16_align_unit.sv
// Multicycle binary16 operand alignment: order by magnitude, then shift the
// smaller significand right one bit per cycle with guard/round/sticky.
module fp16_align_unit
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       a,
    input  logic [15:0]       b,
    output logic              busy,
    output logic              done,
    output logic              big_sign,
    output logic [EXP_W-1:0]  big_exp,
    output logic [MAN_W-1:0]  big_man,
    output logic [SMAN_W-1:0] small_man,
    output logic              eff_sub,
    output logic              swapped,
    output logic [1:0]        special
);

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic               big_sign_q, big_sign_d;
    logic [EXP_W-1:0]   big_exp_q, big_exp_d;
    logic [MAN_W-1:0]   big_man_q, big_man_d;
    logic [SMAN_W-1:0]  small_man_q, small_man_d;
    logic               eff_sub_q, eff_sub_d;
    logic               swapped_q, swapped_d;
    logic [1:0]         special_q, special_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               sign_a, sign_b;
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [MAN_W-1:0]   man_a, man_b;
    logic               zero_a, zero_b;
    logic               spec_a, spec_b;

    logic               b_wins;
    logic [EXP_W-1:0]   exp_s;
    logic [MAN_W-1:0]   man_s;
    logic [EXP_W-1:0]   diff;
    logic [EXP_W-1:0]   cnt_init;

    fp16_unpack u_unpack_a (
        .word       (a_q),
        .sign       (sign_a),
        .eff_exp    (exp_a),
        .man        (man_a),
        .is_zero    (zero_a),
        .is_special (spec_a)
    );

    fp16_unpack u_unpack_b (
        .word       (b_q),
        .sign       (sign_b),
        .eff_exp    (exp_b),
        .man        (man_b),
        .is_zero    (zero_b),
        .is_special (spec_b)
    );

    always_comb begin
        // A keeps the big slot on equal magnitude.
        b_wins   = (b_q[14:0] > a_q[14:0]);
        exp_s    = b_wins ? exp_a : exp_b;
        man_s    = b_wins ? man_a : man_b;
        diff     = (b_wins ? exp_b : exp_a) - exp_s;
        cnt_init = (diff > EXP_W'(MAX_SHIFT)) ? EXP_W'(MAX_SHIFT) : diff;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        big_sign_d  = big_sign_q;
        big_exp_d   = big_exp_q;
        big_man_d   = big_man_q;
        small_man_d = small_man_q;
        eff_sub_d   = eff_sub_q;
        swapped_d   = swapped_q;
        special_d   = special_q;
        cnt_d       = cnt_q;
        done_d      = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                // The done pulse cycle still counts as busy.
                if (start && !done_q) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                big_sign_d  = b_wins ? sign_b : sign_a;
                big_exp_d   = b_wins ? exp_b : exp_a;
                big_man_d   = b_wins ? man_b : man_a;
                small_man_d = {man_s, GRS_W'(0)};
                eff_sub_d   = a_q[15] ^ b_q[15];
                swapped_d   = b_wins;
                special_d   = {spec_a | spec_b, zero_a | zero_b};
                cnt_d       = cnt_init;
                state_d     = (cnt_init == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                small_man_d = {1'b0, small_man_q[SMAN_W-1:2],
                               small_man_q[1] | small_man_q[0]};
                cnt_d       = cnt_q - EXP_W'(1);
                if (cnt_q == EXP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            big_sign_q  <= 1'b0;
            big_exp_q   <= '0;
            big_man_q   <= '0;
            small_man_q <= '0;
            eff_sub_q   <= 1'b0;
            swapped_q   <= 1'b0;
            special_q   <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            big_sign_q  <= big_sign_d;
            big_exp_q   <= big_exp_d;
            big_man_q   <= big_man_d;
            small_man_q <= small_man_d;
            eff_sub_q   <= eff_sub_d;
            swapped_q   <= swapped_d;
            special_q   <= special_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE) || done_q;
    assign done      = done_q;
    assign big_sign  = big_sign_q;
    assign big_exp   = big_exp_q;
    assign big_man   = big_man_q;
    assign small_man = small_man_q;
    assign eff_sub   = eff_sub_q;
    assign swapped   = swapped_q;
    assign special   = special_q;

endmodule

// File: tb/tb_fp16_align_unit.sv
// Table-driven bench for fp16_align_unit with a result scoreboard.
module tb_fp16_align_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic        big_sign;
    logic [4:0]  big_exp;
    logic [10:0] big_man;
    logic [13:0] small_man;
    logic        eff_sub;
    logic        swapped;
    logic [1:0]  special;

    always #5 clk = ~clk;

    fp16_align_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .big_sign  (big_sign),
        .big_exp   (big_exp),
        .big_man   (big_man),
        .small_man (small_man),
        .eff_sub   (eff_sub),
        .swapped   (swapped),
        .special   (special)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        logic        bs;
        logic [4:0]  be;
        logic [10:0] bm;
        logic [13:0] sm;
        logic        es;
        logic        sw;
        logic [1:0]  sp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [15:0] x, logic [15:0] y, int lat,
                                logic bs, logic [4:0] be, logic [10:0] bm,
                                logic [13:0] sm, logic es, logic sw,
                                logic [1:0] sp);
        vec_t r;
        r.a = x; r.b = y; r.lat = lat; r.bs = bs; r.be = be; r.bm = bm;
        r.sm = sm; r.es = es; r.sw = sw; r.sp = sp;
        return r;
    endfunction

    // Reference alignment: one wide shift plus OR of the lost bits.
    function automatic vec_t model(logic [15:0] x, logic [15:0] y);
        vec_t        r;
        logic [15:0] bg;
        logic [15:0] sm;
        int          eb, es, d, s, v;
        r.a  = x;
        r.b  = y;
        r.sw = (y[14:0] > x[14:0]);
        bg   = r.sw ? y : x;
        sm   = r.sw ? x : y;
        eb   = (bg[14:10] == 5'd0) ? 1 : int'(bg[14:10]);
        es   = (sm[14:10] == 5'd0) ? 1 : int'(sm[14:10]);
        d    = eb - es;
        s    = (d > 14) ? 14 : d;
        v    = ((sm[14:10] != 5'd0) ? (1 << 13) : 0) | (int'(sm[9:0]) << 3);
        r.sm = 14'((v >> s) | (((v & ((1 << s) - 1)) != 0) ? 1 : 0));
        r.bs = bg[15];
        r.be = 5'(eb);
        r.bm = {bg[14:10] != 5'd0, bg[9:0]};
        r.es = x[15] ^ y[15];
        r.sp = {(x[14:10] == 5'h1F) || (y[14:10] == 5'h1F),
                (x[14:0] == 15'd0) || (y[14:0] == 15'd0)};
        r.lat = 2 + s;
        return r;
    endfunction

    task automatic check_zero_outputs(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_outs"},
            32'({big_sign, big_exp, big_man, eff_sub, swapped, special}),
            32'd0);
        chk({tag, "_small_man"}, 32'(small_man), 32'd0);
    endtask

    // glitch >= 0 pulses start with junk operands that many cycles in.
    task automatic run_op(vec_t e, int glitch);
        int   lat;
        bit   got;
        vec_t x;
        @(negedge clk);
        a = e.a;
        b = e.b;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            if (lat == glitch) begin
                start = 1'b1;
                a = 16'($urandom);
                b = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        x = sb.pop_front();
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout a=%h b=%h", x.a, x.b);
        end else begin
            chk("latency", 32'(lat), 32'(x.lat));
            chk("big_sign", 32'(big_sign), 32'(x.bs));
            chk("big_exp", 32'(big_exp), 32'(x.be));
            chk("big_man", 32'(big_man), 32'(x.bm));
            chk("small_man", 32'(small_man), 32'(x.sm));
            chk("eff_sub", 32'(eff_sub), 32'(x.es));
            chk("swapped", 32'(swapped), 32'(x.sw));
            chk("special", 32'(special), 32'(x.sp));
            start = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("done_pulse", 32'(done), 32'd0);
            chk("start_in_done_ignored", 32'(busy), 32'd0);
            chk("hold_small_man", 32'(small_man), 32'(x.sm));
        end
    endtask

    initial begin
        int ndone;
        tbl.push_back(mk(16'h3C00, 16'h3800, 3, 0, 5'd15, 11'h400,
                         14'h1000, 0, 0, 2'b00));
        tbl.push_back(mk(16'h3800, 16'hBC00, 3, 1, 5'd15, 11'h400,
                         14'h1000, 1, 1, 2'b00));
        tbl.push_back(mk(16'h4000, 16'h4000, 2, 0, 5'd16, 11'h400,
                         14'h2000, 0, 0, 2'b00));
        tbl.push_back(mk(16'h7800, 16'h3C00, 16, 0, 5'd30, 11'h400,
                         14'h0001, 0, 0, 2'b00));
        tbl.push_back(mk(16'h3C00, 16'h0001, 16, 0, 5'd15, 11'h400,
                         14'h0001, 0, 0, 2'b00));
        tbl.push_back(mk(16'h7C00, 16'h0000, 16, 0, 5'd31, 11'h400,
                         14'h0000, 0, 0, 2'b11));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(model(16'($urandom), 16'($urandom)));
        end

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i], -1);
        end

        // Start pulsed mid-SHIFT must not disturb the operation in flight.
        run_op(tbl[3], 2);

        // Reset during SHIFT discards the operation.
        @(negedge clk);
        a = 16'h7800;
        b = 16'h3C00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 16'h3C00;
        b = 16'h3800;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("mid_reset");
        reset = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("no_done_after_reset", 32'(ndone), 32'd0);

        run_op(tbl[0], -1);
        run_op(tbl[5], -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
